// File: rtl/ctrl_completion_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_completion_collector_pkg
// Description : Shared types, sizing constants and the round-robin helper for
//               the writeback completion collector.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_completion_collector_pkg;

  localparam int ISSUE_WIDTH     = 4;
  localparam int COMMIT_PORTS    = 2;
  localparam int COLLECTOR_DEPTH = 4;
  // Two packets can still be in RR/EX/WB after almostFull is seen.
  localparam int AF_MARGIN       = 2;
  localparam int AL_IDX_W        = 7;
  localparam int LANE_W          = $clog2(ISSUE_WIDTH);

  typedef struct packed {
    logic                valid;
    logic [AL_IDX_W-1:0] alIdx;
    logic                brTaken;
    logic                exception;
  } ctrlPkt;

  typedef logic [LANE_W-1:0] lane_t;

  // Next lane in round-robin order, wrapping at ISSUE_WIDTH.
  function automatic lane_t rr_next(input lane_t lane);
    if (lane == lane_t'(ISSUE_WIDTH - 1)) return '0;
    return lane + lane_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_completion_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_completion_collector_if
// Description : Writeback-side and active-list-side bundle of the collector.
//               master = pipes/active list, slave = collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_completion_collector_if;
  import ctrl_completion_collector_pkg::*;

  ctrlPkt [ISSUE_WIDTH-1:0]  ctrlPacket;
  logic   [ISSUE_WIDTH-1:0]  almostFull;
  logic   [COMMIT_PORTS-1:0] alWrValid;
  ctrlPkt [COMMIT_PORTS-1:0] alWrPacket;

  modport master (output ctrlPacket, input almostFull, alWrValid, alWrPacket);
  modport slave  (input ctrlPacket, output almostFull, alWrValid, alWrPacket);

endinterface
`default_nettype wire

// File: rtl/ctrl_completion_collector_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lane_ctrl_fifo
// Description : Per-lane completion FIFO with flush, occupancy count,
//               registered almost-full flag and overflow (drop) indication.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_ctrl_fifo
  import ctrl_completion_collector_pkg::*;
#(
  parameter int DEPTH = COLLECTOR_DEPTH
) (
  input  wire logic   clk,
  input  wire logic   reset,
  input  wire logic   flush_i,
  input  wire logic   push_i,
  input  wire ctrlPkt push_pkt_i,
  input  wire logic   pop_i,
  output ctrlPkt      head_pkt_o,
  output logic        empty_o,
  output logic        almost_full_o,
  output logic        overflow_o
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_COUNT   = CNT_W'(DEPTH - AF_MARGIN);

  ctrlPkt             mem_q [DEPTH];
  ctrlPkt             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               almost_full_q, almost_full_d;
  logic               do_push, do_pop;

  // Next-state: a pop frees a slot so a push into a full FIFO is still legal.
  always_comb begin
    mem_d         = mem_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    do_pop        = pop_i && (count_q != '0);
    overflow_o    = !flush_i && push_i && (count_q == FULL_COUNT) && !do_pop;
    do_push       = !flush_i && push_i && !overflow_o;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_pkt_i;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (do_pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    almost_full_d = (count_d >= AF_COUNT);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign head_pkt_o    = mem_q[head_q];
  assign empty_o       = (count_q == '0);
  assign almost_full_o = almost_full_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_completion_collector.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_completion_collector
// Description : Collects per-lane writeback completions into lane FIFOs and
//               drains them round-robin into COMMIT_PORTS active-list ports.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_completion_collector
  import ctrl_completion_collector_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  recoverFlag_i,
  input  wire logic                  exceptionFlag_i,
  ctrl_completion_collector_if.slave bus,
  output logic                       overflowErr_o
);

  logic                      flush;
  ctrlPkt [ISSUE_WIDTH-1:0]  head_pkt;
  logic   [ISSUE_WIDTH-1:0]  lane_empty, lane_pop, lane_af, lane_ovf;
  logic   [COMMIT_PORTS-1:0] al_wr_valid;
  ctrlPkt [COMMIT_PORTS-1:0] al_wr_packet;
  lane_t                     rr_ptr_q, rr_ptr_d;
  lane_t                     scan_lane, last_lane;
  logic                      any_grant, taken;
  logic                      overflow_err_q, overflow_err_d;

  assign flush = recoverFlag_i | exceptionFlag_i;

  generate
    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
      lane_ctrl_fifo #(.DEPTH(COLLECTOR_DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush),
        .push_i       (bus.ctrlPacket[gi].valid),
        .push_pkt_i   (bus.ctrlPacket[gi]),
        .pop_i        (lane_pop[gi]),
        .head_pkt_o   (head_pkt[gi]),
        .empty_o      (lane_empty[gi]),
        .almost_full_o(lane_af[gi]),
        .overflow_o   (lane_ovf[gi])
      );
    end
  endgenerate

  // Round-robin grant from rr_ptr: each non-empty lane takes the lowest free port.
  always_comb begin
    al_wr_valid    = '0;
    al_wr_packet   = '0;
    lane_pop       = '0;
    scan_lane      = rr_ptr_q;
    last_lane      = rr_ptr_q;
    any_grant      = 1'b0;
    taken          = 1'b0;
    if (!flush) begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        taken = 1'b0;
        if (!lane_empty[scan_lane]) begin
          for (int p = 0; p < COMMIT_PORTS; p++) begin
            if (!taken && !al_wr_valid[p]) begin
              al_wr_valid[p]        = 1'b1;
              al_wr_packet[p]       = head_pkt[scan_lane];
              al_wr_packet[p].valid = 1'b1;
              lane_pop[scan_lane]   = 1'b1;
              last_lane             = scan_lane;
              any_grant             = 1'b1;
              taken                 = 1'b1;
            end
          end
        end
        scan_lane = rr_next(scan_lane);
      end
    end
    rr_ptr_d       = flush ? '0 : (any_grant ? rr_next(last_lane) : rr_ptr_q);
    overflow_err_d = overflow_err_q | (|lane_ovf);
  end

  // Arbiter pointer and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q       <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Simulation-only notice that an issued completion was dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_WIDTH; i++)
      assert (!(reset && lane_ovf[i])) else $warning("lane %0d full: completion dropped", i);
  end

  assign bus.alWrValid  = al_wr_valid;
  assign bus.alWrPacket = al_wr_packet;
  assign bus.almostFull = lane_af;
  assign overflowErr_o  = overflow_err_q;

endmodule
`default_nettype wire
